// File: rtl/mmio_pkg.sv
// ============================================================================
// mmio_pkg : shared I/O window geometry, register offsets and offset decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package mmio_pkg;

  localparam int IO_WIN_W = 12;

  localparam logic [IO_WIN_W-1:0] OFF_DISP = 12'h000;
  localparam logic [IO_WIN_W-1:0] OFF_TVAL = 12'h020;
  localparam logic [IO_WIN_W-1:0] OFF_TDIV = 12'h024;
  localparam logic [IO_WIN_W-1:0] OFF_LED  = 12'h060;
  localparam logic [IO_WIN_W-1:0] OFF_SW   = 12'h070;
  localparam logic [IO_WIN_W-1:0] OFF_BTN  = 12'h078;

  typedef enum logic [2:0] {
    REG_NONE = 3'd0,
    REG_DISP = 3'd1,
    REG_TVAL = 3'd2,
    REG_TDIV = 3'd3,
    REG_LED  = 3'd4,
    REG_SW   = 3'd5,
    REG_BTN  = 3'd6
  } io_reg_e;

  // Word-granular decode: the byte-lane bits never reach this function.
  function automatic io_reg_e decode_reg(input logic [IO_WIN_W-1:2] word);
    io_reg_e sel;
    sel = REG_NONE;
    if (word == OFF_DISP[IO_WIN_W-1:2]) sel = REG_DISP;
    if (word == OFF_TVAL[IO_WIN_W-1:2]) sel = REG_TVAL;
    if (word == OFF_TDIV[IO_WIN_W-1:2]) sel = REG_TDIV;
    if (word == OFF_LED[IO_WIN_W-1:2])  sel = REG_LED;
    if (word == OFF_SW[IO_WIN_W-1:2])   sel = REG_SW;
    if (word == OFF_BTN[IO_WIN_W-1:2])  sel = REG_BTN;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_bridge_btn_capture.sv
// ============================================================================
// btn_capture : per-bit 2-flop sync, rising-edge detect, sticky W1C flags
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_capture #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] flag
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_flag;
  logic [WIDTH-1:0] w_rise;

  assign w_rise = r_sync & ~r_prev;
  assign flag   = r_flag;

  // Edge is OR-ed after the clear so a simultaneous set always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
      r_flag <= '0;
    end else begin
      r_meta <= btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_flag <= (r_flag & ~clr) | w_rise;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_bridge.sv
// ============================================================================
// mmio_bridge : core data-bus decoder routing accesses to DRAM or board I/O
// Rev 1.0
// ============================================================================
`default_nettype none

module mmio_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE       = 32'hFFFF_F000,
  parameter logic [31:0] TIMER_DIV_RST = 32'd24_999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] adr,
  input  logic [31:0] wdin,
  input  logic        we,
  output logic [31:0] rd,
  output logic [31:0] dram_adr,
  output logic [31:0] dram_wdin,
  output logic        dram_we,
  input  logic [31:0] dram_rd,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [31:0] disp_data
);

  logic        w_io_sel;
  io_reg_e     w_reg;
  logic        w_wr;
  logic        w_tdiv_wr;
  logic        w_tval_wr;
  logic        w_tick;
  logic [4:0]  w_btn_clr;
  logic [4:0]  w_btn_flag;
  logic [31:0] w_io_rdata;

  logic [31:0] r_disp;
  logic [23:0] r_led;
  logic [23:0] r_sw_meta;
  logic [23:0] r_sw_sync;
  logic [31:0] r_tval;
  logic [31:0] r_tdiv;
  logic [31:0] r_pcnt;

  assign w_io_sel  = (adr[31:IO_WIN_W] == IO_BASE[31:IO_WIN_W]);
  assign w_reg     = w_io_sel ? decode_reg(adr[IO_WIN_W-1:2]) : REG_NONE;
  assign w_wr      = we & w_io_sel;
  assign w_tdiv_wr = w_wr && (w_reg == REG_TDIV);
  assign w_tval_wr = w_wr && (w_reg == REG_TVAL);
  assign w_tick    = (r_pcnt == r_tdiv);
  assign w_btn_clr = (w_wr && (w_reg == REG_BTN)) ? wdin[4:0] : 5'd0;

  assign dram_adr  = adr;
  assign dram_wdin = wdin;
  assign dram_we   = we & ~w_io_sel;
  assign led       = r_led;
  assign disp_data = r_disp;

  btn_capture #(
    .WIDTH (5)
  ) u_btn_capture (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .clr   (w_btn_clr),
    .flag  (w_btn_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp    <= '0;
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      if (w_wr && (w_reg == REG_DISP)) r_disp <= wdin;
      if (w_wr && (w_reg == REG_LED))  r_led  <= wdin[23:0];
    end
  end

  // A divisor write restarts the prescaler and suppresses that cycle's tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdiv <= TIMER_DIV_RST;
      r_pcnt <= '0;
      r_tval <= '0;
    end else begin
      if (w_tdiv_wr) begin
        r_tdiv <= wdin;
        r_pcnt <= '0;
      end else begin
        r_pcnt <= w_tick ? 32'd0 : r_pcnt + 32'd1;
      end
      if (w_tval_wr)
        r_tval <= wdin;
      else if (w_tick && !w_tdiv_wr)
        r_tval <= r_tval + 32'd1;
    end
  end

  always_comb begin
    w_io_rdata = '0;
    case (w_reg)
      REG_DISP: w_io_rdata = r_disp;
      REG_TVAL: w_io_rdata = r_tval;
      REG_TDIV: w_io_rdata = r_tdiv;
      REG_LED:  w_io_rdata = {8'h00, r_led};
      REG_SW:   w_io_rdata = {8'h00, r_sw_sync};
      REG_BTN:  w_io_rdata = {27'h0, w_btn_flag};
      default:  w_io_rdata = '0;
    endcase
  end

  assign rd = w_io_sel ? w_io_rdata : dram_rd;

endmodule

`default_nettype wire
